// File: rtl/frame_sync_pkg.sv
// Shared types and constants for the serial frame synchroniser.
package frame_sync_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

endpackage

// File: rtl/serial_frame_sync_sync_matcher.sv
// Sync-word matcher: shift register of the last SYNC_WIDTH bits; match is combinational on the accepted bit.
// Zero-latency compare against the incoming bit; never stalls, shifts on every din_valid.
module sync_matcher #(
  parameter int                    SYNC_WIDTH = 8,
  parameter logic [SYNC_WIDTH-1:0] SYNC_WORD  = 8'hA5
) (
  input  logic clk,
  input  logic reset,
  input  logic din_valid,
  input  logic din,
  output logic match
);

  logic [SYNC_WIDTH-1:0] sr;
  logic [SYNC_WIDTH-1:0] sr_next;

  assign sr_next = {sr[SYNC_WIDTH-2:0], din};
  assign match   = din_valid && (sr_next == SYNC_WORD);

  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
    end else if (din_valid) begin
      sr <= sr_next;
    end
  end

endmodule

// File: rtl/serial_frame_sync.sv
// Frame sync controller: hunts for SYNC_WORD, flywheels over sync misses, deserialises payload bytes.
// Bytes appear one cycle after their 8th bit; input is never stalled, an unaccepted byte is overwritten.
module serial_frame_sync
  import frame_sync_pkg::*;
#(
  parameter int                    SYNC_WIDTH    = 8,
  parameter logic [SYNC_WIDTH-1:0] SYNC_WORD     = 8'hA5,
  parameter int                    PAYLOAD_BYTES = 2,
  parameter int                    MAX_MISS      = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din_valid,
  input  logic              din,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              locked,
  output logic              sync_pulse,
  output logic              overflow,
  output logic [3:0]        miss_count
);

  state_t              state, state_n;
  logic [3:0]          bit_cnt, bit_cnt_n;
  logic [7:0]          byte_cnt, byte_cnt_n;
  logic [BYTE_W-2:0]   byte_asm, byte_asm_n;
  logic [BYTE_W-1:0]   out_data_n;
  logic                out_valid_n;
  logic                locked_n;
  logic                sync_pulse_n;
  logic                overflow_n;
  logic [3:0]          miss_count_n;
  logic                match;

  sync_matcher #(
    .SYNC_WIDTH (SYNC_WIDTH),
    .SYNC_WORD  (SYNC_WORD)
  ) u_matcher (
    .clk       (clk),
    .reset     (reset),
    .din_valid (din_valid),
    .din       (din),
    .match     (match)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HUNT;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      byte_asm   <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      locked     <= 1'b0;
      sync_pulse <= 1'b0;
      overflow   <= 1'b0;
      miss_count <= '0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      byte_cnt   <= byte_cnt_n;
      byte_asm   <= byte_asm_n;
      out_data   <= out_data_n;
      out_valid  <= out_valid_n;
      locked     <= locked_n;
      sync_pulse <= sync_pulse_n;
      overflow   <= overflow_n;
      miss_count <= miss_count_n;
    end
  end

  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    byte_cnt_n   = byte_cnt;
    byte_asm_n   = byte_asm;
    out_data_n   = out_data;
    out_valid_n  = out_valid;
    sync_pulse_n = 1'b0;
    overflow_n   = 1'b0;
    miss_count_n = miss_count;

    if (out_valid && out_ready) begin
      out_valid_n = 1'b0;
    end

    if (din_valid) begin
      case (state)
        HUNT: begin
          if (match) begin
            state_n      = PAYLOAD;
            bit_cnt_n    = '0;
            byte_cnt_n   = '0;
            miss_count_n = '0;
            sync_pulse_n = 1'b1;
          end
        end

        PAYLOAD: begin
          byte_asm_n = {byte_asm[BYTE_W-3:0], din};
          if (bit_cnt == 4'd7) begin
            bit_cnt_n   = '0;
            out_data_n  = {byte_asm, din};
            out_valid_n = 1'b1;
            // Only a byte that nobody took this cycle counts as lost.
            overflow_n  = out_valid && !out_ready;
            if (byte_cnt == 8'(PAYLOAD_BYTES - 1)) begin
              byte_cnt_n = '0;
              state_n    = CHECK;
            end else begin
              byte_cnt_n = byte_cnt + 8'd1;
            end
          end else begin
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end

        CHECK: begin
          if (bit_cnt == 4'(SYNC_WIDTH - 1)) begin
            bit_cnt_n = '0;
            if (match) begin
              miss_count_n = '0;
              sync_pulse_n = 1'b1;
              state_n      = PAYLOAD;
            end else if (miss_count + 4'd1 == 4'(MAX_MISS)) begin
              miss_count_n = '0;
              state_n      = HUNT;
            end else begin
              // Flywheel: trust the expected frame position for one more frame.
              miss_count_n = miss_count + 4'd1;
              state_n      = PAYLOAD;
            end
          end else begin
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end

        default: begin
          state_n = HUNT;
        end
      endcase
    end

    locked_n = (state_n != HUNT);
  end

endmodule

// File: tb/tb_serial_frame_sync.sv
// Scoreboarded bench for serial_frame_sync: directed frames, flywheel misses, overflow, gaps and mid-frame reset.
module tb_serial_frame_sync;

  typedef struct packed {
    logic       pulse;
    logic       lck;
    logic [3:0] miss;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       din_valid = 1'b0;
  logic       din = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_valid;
  logic       locked;
  logic       sync_pulse;
  logic       overflow;
  logic [3:0] miss_count;

  int vectors = 0;
  int fails   = 0;
  int ovf_seen = 0;
  bit mon_en  = 1'b0;
  bit gaps_on = 1'b0;

  logic [7:0] byte_q[$];
  ev_t        ev_q[$];

  logic       prev_locked = 1'b0;
  logic [3:0] prev_miss   = 4'd0;
  logic       prev_pulse  = 1'b0;
  logic       prev_ovf    = 1'b0;

  serial_frame_sync dut (
    .clk        (clk),
    .reset      (reset),
    .din_valid  (din_valid),
    .din        (din),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .locked     (locked),
    .sync_pulse (sync_pulse),
    .overflow   (overflow),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: bytes on handshake, lock/miss/pulse events on change, pulse widths.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid && out_ready) begin
        if (byte_q.size() == 0) begin
          check("unexpected_byte", {24'd0, out_data}, 32'hFFFF_FFFF);
        end else begin
          check("out_data", {24'd0, out_data}, {24'd0, byte_q.pop_front()});
        end
      end
      if (sync_pulse || locked !== prev_locked || miss_count !== prev_miss) begin
        if (ev_q.size() == 0) begin
          check("unexpected_event", {26'd0, sync_pulse, locked, miss_count}, 32'hFFFF_FFFF);
        end else begin
          check("sync_event", {26'd0, sync_pulse, locked, miss_count}, {26'd0, ev_q.pop_front()});
        end
      end
      if (overflow) begin
        ovf_seen++;
        check("overflow_single", {31'd0, prev_ovf}, 32'd0);
      end
      if (sync_pulse) begin
        check("pulse_single", {31'd0, prev_pulse}, 32'd0);
      end
    end
    prev_locked = locked;
    prev_miss   = miss_count;
    prev_pulse  = sync_pulse;
    prev_ovf    = overflow;
  end

  task automatic send_bit(input logic b);
    if (gaps_on && $urandom_range(0, 2) == 0) begin
      din_valid = 1'b0;
      repeat ($urandom_range(1, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    din_valid = 1'b1;
    din       = b;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      send_bit(v[i]);
    end
  endtask

  task automatic sync_ok(input logic [7:0] v);
    ev_q.push_back('{pulse: 1'b1, lck: 1'b1, miss: 4'd0});
    send_byte(v);
  endtask

  task automatic payload(input logic [7:0] a, input logic [7:0] b);
    byte_q.push_back(a);
    byte_q.push_back(b);
    send_byte(a);
    send_byte(b);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    check("timeout", 32'd1, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    idle(3);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_sync_pulse", {31'd0, sync_pulse}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_miss", {28'd0, miss_count}, 32'd0);
    mon_en = 1'b1;
    reset  = 1'b0;
    idle(2);

    // Lock and two clean frames.
    sync_ok(8'hA5);
    payload(8'h3C, 8'h5A);
    sync_ok(8'hA5);
    payload(8'hC3, 8'h96);

    // Three missed syncs: flywheel twice, then drop lock.
    ev_q.push_back('{pulse: 1'b0, lck: 1'b1, miss: 4'd1});
    send_byte(8'h00);
    payload(8'h01, 8'h02);
    ev_q.push_back('{pulse: 1'b0, lck: 1'b1, miss: 4'd2});
    send_byte(8'h00);
    payload(8'h03, 8'h04);
    ev_q.push_back('{pulse: 1'b0, lck: 1'b0, miss: 4'd0});
    send_byte(8'h00);
    idle(2);

    // Relock, then stall downstream across two bytes: 0x11 is overwritten.
    sync_ok(8'hA5);
    out_ready = 1'b0;
    byte_q.push_back(8'h22);
    send_byte(8'h11);
    send_byte(8'h22);
    idle(3);
    check("hold_valid", {31'd0, out_valid}, 32'd1);
    check("hold_data", {24'd0, out_data}, 32'h22);
    check("ovf_count_hold", ovf_seen, 32'd1);
    out_ready = 1'b1;
    idle(2);
    check("released_valid", {31'd0, out_valid}, 32'd0);

    // Same traffic with random input gaps.
    gaps_on = 1'b1;
    sync_ok(8'hA5);
    payload(8'h3C, 8'h5A);
    sync_ok(8'hA5);
    payload(8'hC3, 8'h96);
    gaps_on = 1'b0;
    idle(2);

    // Reset mid-byte with a pending unaccepted byte, then relock.
    sync_ok(8'hA5);
    out_ready = 1'b0;
    send_byte(8'h77);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    ev_q.push_back('{pulse: 1'b0, lck: 1'b0, miss: 4'd0});
    reset = 1'b1;
    idle(1);
    check("mid_rst_locked", {31'd0, locked}, 32'd0);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_data", {24'd0, out_data}, 32'd0);
    check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    idle(1);
    sync_ok(8'hA5);
    byte_q.push_back(8'h42);
    send_byte(8'h42);
    idle(20);

    check("bytes_drained", byte_q.size(), 32'd0);
    check("events_drained", ev_q.size(), 32'd0);
    check("ovf_total", ovf_seen, 32'd1);
    check("final_locked", {31'd0, locked}, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/serial_frame_sync.md
# serial_frame_sync

Frame-synchronisation controller for a single-bit serial receive stream. It hunts for a fixed sync word and locks onto the frame. It then de-serialises a fixed number of payload bytes per frame, re-verifies the sync word at every frame boundary with a miss-tolerant flywheel, and hands bytes downstream over a valid/ready interface. It sits between the serial bit-level front end and the byte-level packet logic.

## Interface
- SYNC_WIDTH, 8, sync word length in bits (2..16)
- SYNC_WORD, 8'hA5, sync pattern, MSB received first; must be nonzero
- PAYLOAD_BYTES, 2, payload bytes per frame (1..255)
- MAX_MISS, 3, consecutive sync misses that drop lock (1..15)
- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high
- din_valid  in  1  din carries a bit this cycle
- din  in  1  serial data bit
- out_data  out  8  received payload byte
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts byte
- locked  out  1  frame lock held
- sync_pulse  out  1  one-cycle pulse on every matched sync word
- overflow  out  1  one-cycle pulse when an unaccepted byte is overwritten
- miss_count  out  4  current consecutive-miss count

## Operation
- Bit shift register sr[SYNC_WIDTH-1:0] shifts on every din_valid: sr_next = {sr[SYNC_WIDTH-2:0], din}. Cycles with din_valid=0 change nothing except output handshake.
- States: HUNT, PAYLOAD, CHECK.
- HUNT: on an accepted bit with sr_next==SYNC_WORD -> PAYLOAD, bit/byte counters cleared, miss_count=0, sync_pulse.
- PAYLOAD: payload bits are shifted MSB-first into a byte assembler. On the 8th bit, the byte is loaded into out_data. After byte PAYLOAD_BYTES-1 completes -> CHECK with bit counter cleared.
- CHECK: counts SYNC_WIDTH accepted bits. On the last one:
  - sr_next==SYNC_WORD: miss_count=0, sync_pulse, -> PAYLOAD.
  - else miss_count+1. If that equals MAX_MISS -> HUNT, miss_count=0. Otherwise -> PAYLOAD (flywheel: frame assumed at expected position).
- locked = 1 in PAYLOAD and CHECK, 0 in HUNT.
- Output handshake:
  - A completed byte sets out_valid. out_valid&&out_ready clears it.
  - If a byte completes while out_valid=1 and out_ready=0: out_data is overwritten, out_valid stays 1, overflow pulses.
  - If out_ready=1 in that same cycle: the old byte is accepted, the new byte is loaded, out_valid stays 1, no overflow.
- Bytes already emitted from a frame whose trailing sync misses are not retracted.
- Serial input is never stalled; there is no backpressure toward din.

## Timing
- Reset values: state HUNT, sr=0, all counters 0, out_data=0, out_valid=0, locked=0, sync_pulse=0, overflow=0, miss_count=0.
- Reset mid-operation discards partial bytes, any pending out_valid byte, and lock.
- All outputs are registered.
- sync_pulse, locked rise, out_valid rise, overflow, miss_count update, and locked fall all occur in the cycle after the clock edge that accepted the triggering bit.
- Byte latency: out_valid=1 one cycle after the 8th payload bit is accepted.
- Overlapping sync words are allowed in HUNT because sr matches on every bit.
- In PAYLOAD, sr contents are ignored for state decisions.
- sync_pulse and overflow never assert for more than one cycle per event.

## Structure
- Shared package frame_sync_pkg: state enum {HUNT, PAYLOAD, CHECK}, byte width constant 8.
- Sub-module sync_matcher: holds sr and produces a combinational match = (sr_next==SYNC_WORD) on din_valid. It is parameterised by SYNC_WIDTH and SYNC_WORD.
- The FSM, counters, byte assembler and handshake live in the top level.

## Test plan
- After reset, send bits 0xA5, 0x3C, 0x5A MSB-first with out_ready=1. Expected:
  - sync_pulse one cycle after the 8th sync bit, and locked=1.
  - out_data=0x3C, then 0x5A, each with a one-cycle out_valid.
- Continue with sync 0xA5 plus two payload bytes. Expected: sync_pulse, miss_count stays 0, locked stays 1.
- Send three consecutive frames with sync 0x00. Expected:
  - miss_count goes 1, then 2.
  - On the third miss, locked=0, miss_count=0, state HUNT.
  - The payload bytes of the first two missed frames are still emitted.
- Hold out_ready=0 across two payload bytes 0x11, 0x22. Expected: one overflow pulse, out_data=0x22, out_valid=1 until out_ready=1.
- Insert random din_valid=0 gaps inside sync and payload. Expected: identical out_data sequence and lock behaviour to the gap-free run.
- Assert reset after 4 payload bits with out_valid=1. Expected: all outputs return to reset values next cycle, and a fresh 0xA5 relocks.
